// File: rtl/time_adjust_ctrl.sv
// Button front end for the timing clock: debounces sel/add/sub buttons, rotates the
// selected field, and turns add/sub presses into stretched one-hot request pulses.
module time_adjust_ctrl #(
  parameter int WIDTH         = 32,
  parameter int DEB_CYCLES    = 20,
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100,
  parameter int PULSE_CYCLES  = 4
) (
  input  logic       clk_src,
  input  logic       reset,
  input  logic       adjust_en,
  input  logic       btn_sel,
  input  logic       btn_add,
  input  logic       btn_sub,
  output logic [2:0] field_sel,
  output logic [2:0] add_time,
  output logic [2:0] sub_time
);

  typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;

  // button index: 0 = sel, 1 = add, 2 = sub
  logic [2:0]       raw_s;
  logic [2:0]       sync1_r, sync2_r, deb_r;
  logic [WIDTH-1:0] deb_cnt_r [3];
  logic             sel_d_r, adj_d_r, armed_r, dir_r, dir_n;
  logic             add_d_s, sub_d_s, sel_rise_s, start_s;
  logic [WIDTH-1:0] tmr_r, pcnt_r;
  state_t           state_r, state_n;

  assign raw_s      = {btn_sub, btn_add, btn_sel};
  assign add_d_s    = deb_r[1];
  assign sub_d_s    = deb_r[2];
  assign sel_rise_s = deb_r[0] & ~sel_d_r;

  // two-flop synchronizers and per-button debounce counters
  always_ff @(posedge clk_src or negedge reset) begin
    if (!reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      deb_r   <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_r[i] <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == WIDTH'(DEB_CYCLES - 1)) begin
            deb_r[i]     <= ~deb_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + WIDTH'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // field rotation on sel press; leaving adjust mode snaps back to seconds
  always_ff @(posedge clk_src or negedge reset) begin
    if (!reset) begin
      sel_d_r   <= 1'b0;
      adj_d_r   <= 1'b0;
      field_sel <= 3'b001;
    end else begin
      sel_d_r <= deb_r[0];
      adj_d_r <= adjust_en;
      if (adj_d_r && !adjust_en) begin
        field_sel <= 3'b001;
      end else if (adjust_en && sel_rise_s) begin
        field_sel <= {field_sel[1:0], field_sel[2]};
      end else begin
        field_sel <= field_sel;
      end
    end
  end

  // action FSM next state; the first pulse launches on the IDLE exit edge
  always_comb begin
    state_n = state_r;
    dir_n   = dir_r;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (adjust_en && armed_r && (add_d_s != sub_d_s)) begin
          state_n = FIRST;
          dir_n   = sub_d_s;
          start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      FIRST: state_n = HOLD;
      HOLD, REPEAT: begin
        if (!adjust_en || (dir_r ? (!sub_d_s || add_d_s) : (!add_d_s || sub_d_s))) begin
          state_n = IDLE;
        end else if (tmr_r == '0) begin
          state_n = REPEAT;
          start_s = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, direction, re-arm flag and hold/repeat timer
  always_ff @(posedge clk_src or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      dir_r   <= 1'b0;
      armed_r <= 1'b0;
      tmr_r   <= '0;
    end else begin
      state_r <= state_n;
      dir_r   <= dir_n;
      if (!add_d_s && !sub_d_s) begin
        armed_r <= 1'b1;
      end else if (start_s && (state_r == IDLE)) begin
        armed_r <= 1'b0;
      end else begin
        armed_r <= armed_r;
      end
      if (start_s) begin
        tmr_r <= (state_r == IDLE) ? WIDTH'(HOLD_CYCLES - 1) : WIDTH'(REPEAT_CYCLES - 1);
      end else if (tmr_r != '0) begin
        tmr_r <= tmr_r - WIDTH'(1);
      end else begin
        tmr_r <= tmr_r;
      end
    end
  end

  // stretched output pulses; a new start takes over both outputs so they stay exclusive
  always_ff @(posedge clk_src or negedge reset) begin
    if (!reset) begin
      add_time <= 3'b000;
      sub_time <= 3'b000;
      pcnt_r   <= '0;
    end else if (start_s) begin
      pcnt_r   <= WIDTH'(PULSE_CYCLES - 1);
      add_time <= dir_n ? 3'b000 : field_sel;
      sub_time <= dir_n ? field_sel : 3'b000;
    end else if (pcnt_r != '0) begin
      pcnt_r   <= pcnt_r - WIDTH'(1);
    end else begin
      add_time <= 3'b000;
      sub_time <= 3'b000;
    end
  end

endmodule

// File: doc/time_adjust_ctrl.md
Name: time_adjust_ctrl

Overview:
- Upstream stage of the timing clock alarm. Converts raw, bouncing push-buttons into clean per-field add/sub request pulses that drive the `add_time[2:0]` and `sub_time[2:0]` inputs of the timing clock.
- Provides debounce, field selection (sec/min/hour), press-and-hold auto-repeat, and pulse stretching. The stretching ensures requests survive sampling by the slower change-time clock.

Parameters:
WIDTH, 32, width of internal debounce/hold counters
DEB_CYCLES, 20, consecutive stable synchronized samples required to accept a button level change
HOLD_CYCLES, 500, cycles from first pulse start to first auto-repeat pulse start
REPEAT_CYCLES, 100, period between auto-repeat pulse starts; must exceed PULSE_CYCLES
PULSE_CYCLES, 4, high duration of each emitted add/sub pulse

Ports:
clk_src  input  1  single block clock
reset  input  1  asynchronous, active-low reset
adjust_en  input  1  adjust mode enable (tied to timing_clock_switch)
btn_sel  input  1  raw field-select button, active-high, asynchronous
btn_add  input  1  raw increment button, active-high, asynchronous
btn_sub  input  1  raw decrement button, active-high, asynchronous
field_sel  output  3  one-hot selected field: [0]=sec, [1]=min, [2]=hour
add_time  output  3  increment request, one-hot on selected field, stretched pulse
sub_time  output  3  decrement request, one-hot on selected field, stretched pulse

Behaviour:
- Reset (reset=0, async):
  - all sync flops, debounced levels and counters cleared.
  - field_sel=3'b001; add_time=sub_time=3'b000; FSM=IDLE.
  - Release is synchronous to clk_src.
- Input conditioning, applied to each button:
  - 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized value differs from the debounced level and clears otherwise.
  - When the count reaches DEB_CYCLES, the debounced level toggles and the counter clears.
  - Glitches shorter than DEB_CYCLES are never accepted.
- Field select:
  - On a debounced rising edge of btn_sel while adjust_en=1, field_sel rotates 001→010→100→001.
  - The falling edge of adjust_en forces field_sel=001.
  - btn_sel is ignored while adjust_en=0.
- Action FSM, shared by add and sub:
  - IDLE:
    - debounced add=1 and sub=0 (and adjust_en=1) → FIRST, dir=add.
    - sub=1 and add=0 → FIRST, dir=sub.
    - both 1 → stay IDLE; no pulse.
  - FIRST: emit one pulse; load hold counter with HOLD_CYCLES; → HOLD.
  - HOLD: count down; at 0 → REPEAT and emit a pulse.
  - REPEAT: emit a pulse every REPEAT_CYCLES.
  - Exits: in HOLD or REPEAT, debounced active button released, other button pressed, or adjust_en=0 → IDLE. Return to IDLE is immediate, with no new pulse.
  - Direction is latched at FIRST. Pressing the opposite button while one is held aborts to IDLE; a new FIRST requires both buttons to be released first.
- Pulse generation:
  - Each emitted pulse drives add_time (or sub_time) = field_sel, captured at pulse start, for exactly PULSE_CYCLES cycles.
  - An in-flight pulse always completes even if the FSM returns to IDLE, adjust_en drops, or field_sel changes.
  - add_time and sub_time are never nonzero simultaneously.
  - Outputs are registered.
- Latency: raw button rising edge (stable) to first add/sub high = DEB_CYCLES+3 cycles (2 sync + DEB_CYCLES + 1 register).
- Auto-repeat timing: pulse starts at t0, t0+HOLD_CYCLES, then t0+HOLD_CYCLES+k·REPEAT_CYCLES.
- Counters saturate/clear; no wrap-around possible within parameter ranges.

Test Plan (DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, PULSE_CYCLES=2):
- Single press: assert reset low then release; field_sel=001. Press btn_add clean for 15 cycles → add_time=001 high on cycles 7–8 after press only; sub_time stays 000.
- Bounce: toggle btn_sub every 2 cycles for 12 cycles, then hold high → no pulse during toggling; one sub_time=001 pulse 7 cycles after the final rising edge.
- Field select and hold: press btn_sel twice (field_sel 001→010→100), then hold btn_add for 50 cycles with first pulse at t0 → add_time=100 pulses start at t0, t0+20, t0+28, t0+36, t0+44, each 2 cycles.
- Conflict: hold btn_add, then press btn_sub during HOLD → FSM returns to IDLE, no further pulses; releasing both then pressing btn_sub gives a single sub pulse.
- adjust_en drop: during REPEAT with a pulse in flight, drop adjust_en → current pulse completes its 2 cycles, no new pulses, field_sel=001.
- Async reset mid-pulse: assert reset while add_time=010 → outputs 000 and field_sel=001 immediately, without waiting for a clock edge.
